// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader
//   Read-side controller for a 128x32 FIFO. Waits until the FIFO holds a full
//   burst, issues BURST_LEN single-word reads, and streams the returned words
//   downstream through a 2-entry skid buffer on a valid/ready interface. The
//   final word of a complete burst is flagged with out_last.
//
//   Optional feature (macro FIFO_DRAIN_TIMEOUT_EN): a partial FIFO that sits
//   idle for TIMEOUT cycles is flushed as a short burst of the current
//   occupancy, with out_last on its final word.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   fifo_empty      FIFO empty flag
//   fifo_status     FIFO occupancy in words
//   data_read       FIFO read data, valid the cycle after read_flag
//   read_flag       FIFO read strobe
//   out_data/out_valid/out_ready/out_last   downstream stream
//   busy            controller not idle
//   err_read        sticky: FIFO emptied mid-burst; cleared by clr_err
module fifo_burst_reader #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 128,
    parameter int LVL_W     = 8,
    parameter int BURST_LEN = 8,
    parameter int TIMEOUT   = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    input  logic [LVL_W-1:0]  fifo_status,
    input  logic [DATA_W-1:0] data_read,
    output logic              read_flag,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              err_read,
    input  logic              clr_err
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [LVL_W-1:0] BL_L = LVL_W'(BURST_LEN);
    localparam logic [CNT_W-1:0] BL_C = CNT_W'(BURST_LEN);

    if (BURST_LEN < 2 || BURST_LEN > DEPTH || TIMEOUT < 1) begin : g_param_chk
        $error("fifo_burst_reader: illegal BURST_LEN/DEPTH/TIMEOUT");
    end

    typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  rd_cnt_q;
    logic [CNT_W-1:0]  len_cur;
    logic              err_q;
    logic              infl_q, infl_last_q;   // read issued last cycle, and its last tag
    logic [DATA_W-1:0] sb_data_q [2];
    logic [DATA_W-1:0] sb_data_d [2];
    logic              sb_last_q [2];
    logic              sb_last_d [2];
    logic [1:0]        sb_cnt_q, sb_cnt_d;
    logic [1:0]        occ;
    logic              pop, credit_ok, rd, rd_last;

`ifdef FIFO_DRAIN_TIMEOUT_EN
    localparam int IDL_W = $clog2(TIMEOUT + 1);
    logic [IDL_W-1:0] idle_q;
    logic [CNT_W-1:0] len_q;
    assign len_cur = len_q;
`else
    assign len_cur = BL_C;
`endif

    assign out_valid = (sb_cnt_q != 2'd0);
    assign out_data  = sb_data_q[0];
    assign out_last  = out_valid & sb_last_q[0];
    assign busy      = (state_q != IDLE);
    assign err_read  = err_q;
    assign pop       = out_valid & out_ready;

    // Space check counts the entry popped this cycle so a steady stream runs
    // at one word per clock: occupancy + in-flight must leave one slot free.
    assign occ       = sb_cnt_q + {1'b0, infl_q};
    assign credit_ok = (occ <= ({1'b0, pop} + 2'd1));

    // Combinational strobe so it can never coincide with fifo_empty, and no
    // read is launched while reset is asserted.
    assign rd      = !rst && (state_q == BURST) && !fifo_empty && credit_ok;
    assign rd_last = rd && (rd_cnt_q == len_cur - 1'b1);
    assign read_flag = rd;

    // Skid buffer: pop shifts entry 1 forward, then the returning word is
    // appended behind whatever remains.
    always_comb begin
        sb_data_d = sb_data_q;
        sb_last_d = sb_last_q;
        sb_cnt_d  = sb_cnt_q;
        if (pop) begin
            sb_data_d[0] = sb_data_q[1];
            sb_last_d[0] = sb_last_q[1];
            sb_cnt_d     = sb_cnt_q - 2'd1;
        end
        if (infl_q) begin
            sb_data_d[sb_cnt_d[0]] = data_read;
            sb_last_d[sb_cnt_d[0]] = infl_last_q;
            sb_cnt_d               = sb_cnt_d + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_data_q[0] <= '0;
            sb_data_q[1] <= '0;
            sb_last_q[0] <= 1'b0;
            sb_last_q[1] <= 1'b0;
            sb_cnt_q     <= 2'd0;
            infl_q       <= 1'b0;
            infl_last_q  <= 1'b0;
        end else begin
            sb_data_q   <= sb_data_d;
            sb_last_q   <= sb_last_d;
            sb_cnt_q    <= sb_cnt_d;
            infl_q      <= rd;
            infl_last_q <= rd_last;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rd_cnt_q <= '0;
            err_q    <= 1'b0;
`ifdef FIFO_DRAIN_TIMEOUT_EN
            idle_q   <= '0;
            len_q    <= BL_C;
`endif
        end else begin
            if (clr_err) err_q <= 1'b0;   // a same-cycle error below overrides
            case (state_q)
                IDLE: begin
                    rd_cnt_q <= '0;
`ifdef FIFO_DRAIN_TIMEOUT_EN
                    if (fifo_status >= BL_L) begin
                        state_q <= BURST;
                        len_q   <= BL_C;
                        idle_q  <= '0;
                    end else if (fifo_status != '0) begin
                        if (idle_q == IDL_W'(TIMEOUT - 1)) begin
                            state_q <= BURST;
                            len_q   <= CNT_W'(fifo_status);
                            idle_q  <= '0;
                        end else begin
                            idle_q <= idle_q + 1'b1;
                        end
                    end else begin
                        idle_q <= '0;
                    end
`else
                    if (fifo_status >= BL_L) state_q <= BURST;
`endif
                end
                BURST: begin
                    if (fifo_empty) begin
                        err_q   <= 1'b1;   // truncated burst: no last tag issued
                        state_q <= DRAIN;
                    end else if (rd) begin
                        rd_cnt_q <= rd_cnt_q + 1'b1;
                        if (rd_last) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (sb_cnt_q == 2'd0 && !infl_q) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_burst_reader.sv
module tb_fifo_burst_reader;
    localparam int DW = 32;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fifo_empty = 1'b1;
    logic [LW-1:0] fifo_status = '0;
    logic [DW-1:0] data_read = '0;
    logic          read_flag;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          out_last;
    logic          busy;
    logic          err_read;
    logic          clr_err = 1'b0;

    fifo_burst_reader dut (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_status(fifo_status),
        .data_read(data_read), .read_flag(read_flag), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .busy(busy), .err_read(err_read), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    bit force_empty = 1'b0;

    logic [DW-1:0] fifo_q [$];   // FIFO contents model
    logic [DW-1:0] exp_q [$];    // every word pushed, in order
    logic [DW-1:0] got_d [$];
    bit            got_l [$];
    int            got_c [$];
    int            rf_c  [$];

    bit            pv, pr, pl;
    logic [DW-1:0] pd;

    task automatic refresh();
        fifo_status = LW'(fifo_q.size());
        fifo_empty  = force_empty || (fifo_q.size() == 0);
    endtask

    task automatic push(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
        refresh();
    endtask

    task automatic clear_logs();
        got_d.delete(); got_l.delete(); got_c.delete(); rf_c.delete(); exp_q.delete();
    endtask

    // One clock: sample DUT at negedge, then update the FIFO model after the edge.
    task automatic tick();
        bit rf;
        @(negedge clk);
        if (!rst) begin
            if (pv && !pr) begin
                tests++;
                if (out_valid !== 1'b1 || out_data !== pd || out_last !== pl) begin
                    fails++;
                    $display("FAIL hold_stable cyc %0d: v=%b d=%h l=%b want v=1 d=%h l=%b",
                             cyc, out_valid, out_data, out_last, pd, pl);
                end
            end
            tests++;
            if (read_flag === 1'b1 && fifo_empty === 1'b1) begin
                fails++;
                $display("FAIL read_while_empty cyc %0d: read_flag=1 want 0", cyc);
            end
            if (out_valid && out_ready) begin
                got_d.push_back(out_data); got_l.push_back(out_last); got_c.push_back(cyc);
            end
            if (read_flag) rf_c.push_back(cyc);
            pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
        end else begin
            pv = 1'b0;
        end
        rf = read_flag;
        @(posedge clk);
        #1;
        if (rf && fifo_q.size() > 0) data_read = fifo_q.pop_front();
        else                         data_read = $urandom;
        refresh();
        cyc++;
    endtask

    task automatic run_until_done(input int n_words, input int bound, input string name);
        int k = 0;
        while (!(got_d.size() >= n_words && !busy) && k < bound) begin
            tick();
            k++;
        end
        tests++;
        if (k >= bound) begin
            fails++;
            $display("FAIL %s_timeout: got %0d words busy=%b want %0d words busy=0",
                     name, got_d.size(), busy, n_words);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        tests++;
        if ({read_flag, out_valid, out_last, busy, err_read} !== 5'b0 || out_data !== '0) begin
            fails++;
            $display("FAIL reset_outputs: rf=%b v=%b l=%b busy=%b err=%b d=%h want all 0",
                     read_flag, out_valid, out_last, busy, err_read, out_data);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        clear_logs();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) push(DW'(i));
        run_until_done(8, 60, "basic");
        tests++;
        if (rf_c.size() != 8 || rf_c[7] - rf_c[0] != 7) begin
            fails++;
            $display("FAIL basic_reads: %0d reads want 8 consecutive", rf_c.size());
        end
        tests++;
        if (got_d.size() != 8 || got_c[0] - rf_c[0] != 2 || got_c[7] - got_c[0] != 7) begin
            fails++;
            $display("FAIL basic_latency: %0d words, want 8 back-to-back 2 cycles after first read",
                     got_d.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                tests++;
                if (got_d[i] !== exp_q[i] || got_l[i] !== (i == 7)) begin
                    fails++;
                    $display("FAIL basic_word%0d: d=%h l=%b want d=%h l=%b",
                             i, got_d[i], got_l[i], exp_q[i], i == 7);
                end
            end
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL basic_busy: busy=%b want 0", busy);
        end
    endtask

    task automatic test_backpressure();
        int k = 0;
        clear_logs();
        for (int i = 0; i < 8; i++) push(DW'(i));
        while (!(got_d.size() >= 8 && !busy) && k < 100) begin
            out_ready = (k % 2 == 0);
            tick();
            k++;
        end
        out_ready = 1'b1;
        tests++;
        if (k >= 100 || got_d.size() != 8 || rf_c.size() != 8) begin
            fails++;
            $display("FAIL bp_count: got %0d words %0d reads want 8 and 8", got_d.size(), rf_c.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                tests++;
                if (got_d[i] !== exp_q[i] || got_l[i] !== (i == 7)) begin
                    fails++;
                    $display("FAIL bp_word%0d: d=%h l=%b want d=%h l=%b",
                             i, got_d[i], got_l[i], exp_q[i], i == 7);
                end
            end
        end
    endtask

    task automatic test_truncate();
        int k = 0;
        clear_logs();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) push($urandom);
        while (rf_c.size() < 3 && k < 30) begin tick(); k++; end
        force_empty = 1'b1;
        refresh();
        run_until_done(3, 40, "trunc");
        tests++;
        if (rf_c.size() != 3 || got_d.size() != 3) begin
            fails++;
            $display("FAIL trunc_count: %0d reads %0d words want 3 and 3", rf_c.size(), got_d.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                tests++;
                if (got_d[i] !== exp_q[i] || got_l[i] !== 1'b0) begin
                    fails++;
                    $display("FAIL trunc_word%0d: d=%h l=%b want d=%h l=0", i, got_d[i], got_l[i], exp_q[i]);
                end
            end
        end
        repeat (10) tick();
        tests++;
        if (err_read !== 1'b1) begin
            fails++;
            $display("FAIL trunc_err_sticky: err=%b want 1", err_read);
        end
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        tests++;
        if (err_read !== 1'b0) begin
            fails++;
            $display("FAIL trunc_err_clear: err=%b want 0", err_read);
        end
        fifo_q.delete();
        force_empty = 1'b0;
        refresh();
        tick();
    endtask

    task automatic test_partial();
        int c0;
        clear_logs();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) push($urandom);
        c0 = cyc;
`ifdef FIFO_DRAIN_TIMEOUT_EN
        run_until_done(5, 200, "partial");
        tests++;
        if (rf_c.size() != 5 || rf_c[0] - c0 < 63 || rf_c[0] - c0 > 66) begin
            fails++;
            $display("FAIL partial_timeout: %0d reads first at +%0d want 5 at about +64",
                     rf_c.size(), rf_c.size() ? rf_c[0] - c0 : -1);
        end
        tests++;
        if (got_d.size() != 5) begin
            fails++;
            $display("FAIL partial_words: %0d words want 5", got_d.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                tests++;
                if (got_d[i] !== exp_q[i] || got_l[i] !== (i == 4)) begin
                    fails++;
                    $display("FAIL partial_word%0d: d=%h l=%b want d=%h l=%b",
                             i, got_d[i], got_l[i], exp_q[i], i == 4);
                end
            end
        end
`else
        repeat (200) tick();
        tests++;
        if (rf_c.size() != 0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL partial_wait: %0d reads busy=%b want 0 reads busy=0", rf_c.size(), busy);
        end
        for (int i = 0; i < 3; i++) push($urandom);
        run_until_done(8, 60, "partial_fill");
        tests++;
        if (got_d.size() != 8) begin
            fails++;
            $display("FAIL partial_fill_words: %0d words want 8", got_d.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                tests++;
                if (got_d[i] !== exp_q[i] || got_l[i] !== (i == 7)) begin
                    fails++;
                    $display("FAIL partial_fill_word%0d: d=%h l=%b want d=%h l=%b",
                             i, got_d[i], got_l[i], exp_q[i], i == 7);
                end
            end
        end
`endif
    endtask

    task automatic test_reset_mid();
        int k = 0;
        clear_logs();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) push($urandom);
        while (rf_c.size() < 4 && k < 30) begin tick(); k++; end
        rst = 1'b1; tick(); rst = 1'b0;
        tests++;
        if ({read_flag, out_valid, out_last, busy, err_read} !== 5'b0 || out_data !== '0) begin
            fails++;
            $display("FAIL midrst_outputs: rf=%b v=%b l=%b busy=%b err=%b d=%h want all 0",
                     read_flag, out_valid, out_last, busy, err_read, out_data);
        end
        got_d.delete(); got_l.delete(); got_c.delete(); rf_c.delete();
        repeat (10) tick();
        tests++;
        if (got_d.size() != 0 || rf_c.size() != 0) begin
            fails++;
            $display("FAIL midrst_quiet: %0d words %0d reads want 0 and 0", got_d.size(), rf_c.size());
        end
        for (int i = 0; i < 4; i++) push($urandom);
        run_until_done(8, 60, "midrst");
        tests++;
        if (got_d.size() != 8) begin
            fails++;
            $display("FAIL midrst_words: %0d words want 8", got_d.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                tests++;
                if (got_d[i] !== exp_q[i+4] || got_l[i] !== (i == 7)) begin
                    fails++;
                    $display("FAIL midrst_word%0d: d=%h l=%b want d=%h l=%b",
                             i, got_d[i], got_l[i], exp_q[i+4], i == 7);
                end
            end
        end
    endtask

    task automatic test_empty_idle();
        clear_logs();
        repeat (100) tick();
        tests++;
        if (rf_c.size() != 0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL empty_idle: %0d reads busy=%b want 0 and 0", rf_c.size(), busy);
        end
    endtask

    task automatic test_random();
        localparam int TOT = 96;
        int pushed = 0;
        int k = 0;
        clear_logs();
        while (!(pushed == TOT && got_d.size() >= TOT && !busy) && k < 3000) begin
            if (pushed < TOT && ($urandom % 2) == 1) begin
                int n = $urandom_range(1, 6);
                for (int j = 0; j < n && pushed < TOT; j++) begin push($urandom); pushed++; end
            end
            out_ready = ($urandom % 4) != 0;
            tick();
            k++;
        end
        out_ready = 1'b1;
        tests++;
        if (got_d.size() != TOT || rf_c.size() != TOT) begin
            fails++;
            $display("FAIL rand_count: %0d words %0d reads want %0d", got_d.size(), rf_c.size(), TOT);
        end else begin
            for (int i = 0; i < TOT; i++) begin
                tests++;
                if (got_d[i] !== exp_q[i] || got_l[i] !== (i % 8 == 7)) begin
                    fails++;
                    $display("FAIL rand_word%0d: d=%h l=%b want d=%h l=%b",
                             i, got_d[i], got_l[i], exp_q[i], i % 8 == 7);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_truncate();
        test_partial();
        test_reset_mid();
        test_empty_idle();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
